// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU address translation/issue unit.
// Exception codes, FSM states, DMW field layout and inter-stage bundles.
package lsu_pkg;

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_ALE  = 3'd1,
    EXC_ADEM = 3'd2,
    EXC_TLBR = 3'd3,
    EXC_PIL  = 3'd4,
    EXC_PIS  = 3'd5,
    EXC_PPI  = 3'd6,
    EXC_PME  = 3'd7
  } exc_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_ISSUE,
    S_DONE
  } state_e;

  localparam int DMW_W    = 10;
  localparam int DMW_PLV0 = 9;
  localparam int DMW_PLV3 = 8;
  localparam int DMW_VSEG = 5;
  localparam int DMW_PSEG = 2;
  localparam int DMW_MAT  = 0;

  localparam logic [5:0] PS_2M = 6'd21;

  typedef struct packed {
    logic [31:0] vaddr;
    logic [31:0] wdata;
    logic        store;
    logic        load;
    logic [1:0]  size;
  } op_t;

  typedef struct packed {
    exc_e        exc;
    logic [31:0] paddr;
    logic [1:0]  mat;
  } res_t;

endpackage

// File: rtl/lsu_dmw_match.sv
// Priority match of a virtual segment against the DMW windows.
// The lowest-numbered hitting window supplies pseg and mat.
module lsu_dmw_match
  import lsu_pkg::*;
#(
  parameter int NUM_DMW = 2
) (
  input  logic [NUM_DMW*DMW_W-1:0] csr_dmw,
  input  logic [1:0]               plv,
  input  logic [2:0]               vseg,
  output logic                     hit,
  output logic [2:0]               pseg,
  output logic [1:0]               mat
);

  // scan high to low so the lowest index overrides
  always_comb begin
    hit  = 1'b0;
    pseg = '0;
    mat  = '0;
    for (int i = NUM_DMW - 1; i >= 0; i--) begin
      if (csr_dmw[i*DMW_W+DMW_VSEG +: 3] == vseg &&
          ((plv == 2'd0 && csr_dmw[i*DMW_W+DMW_PLV0]) ||
           (plv == 2'd3 && csr_dmw[i*DMW_W+DMW_PLV3]))) begin
        hit  = 1'b1;
        pseg = csr_dmw[i*DMW_W+DMW_PSEG +: 3];
        mat  = csr_dmw[i*DMW_W+DMW_MAT +: 2];
      end
    end
  end

endmodule

// File: rtl/lsu_xlate_issue.sv
// EXE-side load/store unit: translate, check, issue to data SRAM.
// Bounds outstanding requests and hands the result to MEM.
module lsu_xlate_issue
  import lsu_pkg::*;
#(
  parameter int NUM_DMW   = 2,
  parameter int MAX_OUTST = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_vaddr,
  input  logic [31:0]              in_wdata,
  input  logic                     in_store,
  input  logic                     in_load,
  input  logic [1:0]               in_size,
  input  logic [1:0]               csr_plv,
  input  logic                     csr_da,
  input  logic [1:0]               csr_datm,
  input  logic [9:0]               csr_asid,
  input  logic [NUM_DMW*DMW_W-1:0] csr_dmw,
  output logic [18:0]              tlb_vppn,
  output logic                     tlb_va_bit12,
  output logic [9:0]               tlb_asid,
  input  logic                     tlb_found,
  input  logic                     tlb_v,
  input  logic                     tlb_d,
  input  logic [19:0]              tlb_ppn,
  input  logic [5:0]               tlb_ps,
  input  logic [1:0]               tlb_plv,
  input  logic [1:0]               tlb_mat,
  output logic                     req,
  output logic                     wr,
  output logic [1:0]               size,
  output logic [3:0]               wstrb,
  output logic [31:0]              addr,
  output logic [31:0]              wdata,
  input  logic                     addr_ok,
  input  logic                     data_ok,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2:0]               out_exc,
  output logic [31:0]              out_paddr,
  output logic [1:0]               out_mat,
  output logic                     out_load
);

  localparam logic [2:0] MAXC = 3'(MAX_OUTST);

  state_e      st, st_n;
  op_t         op;
  res_t        res, xl;
  logic [2:0]  cnt;
  logic [31:0] va;
  logic        accept, fire;
  logic        hit, tlb_path, ale, adem;
  logic [2:0]  dseg;
  logic [1:0]  dmat;

  assign va       = op.vaddr;
  assign in_ready = (st == S_IDLE) |
                    ((st == S_DONE) & out_ready);
  assign accept   = in_ready & in_valid & ~flush;
  assign req      = (st == S_ISSUE) & ~flush &
                    (cnt < MAXC);
  assign fire     = req & addr_ok;

  assign tlb_vppn     = va[31:13];
  assign tlb_va_bit12 = va[12];
  assign tlb_asid     = csr_asid;

  assign wr        = op.store;
  assign size      = op.size;
  assign addr      = res.paddr;
  assign out_valid = (st == S_DONE);
  assign out_exc   = res.exc;
  assign out_paddr = res.paddr;
  assign out_mat   = res.mat;
  assign out_load  = op.load;

  lsu_dmw_match #(.NUM_DMW(NUM_DMW)) u_dmw (
    .csr_dmw (csr_dmw),
    .plv     (csr_plv),
    .vseg    (va[31:29]),
    .hit     (hit),
    .pseg    (dseg),
    .mat     (dmat)
  );

  assign tlb_path = ~csr_da & ~hit;
  assign ale  = (op.size == 2'd1 & va[0]) |
                (op.size == 2'd2 & |va[1:0]);
  assign adem = va[31] & (csr_plv == 2'd3) &
                ~csr_da & ~hit;

  // address translation and prioritised exception check
  always_comb begin
    xl.paddr = va;
    xl.mat   = csr_datm;
    xl.exc   = EXC_NONE;
    if (!csr_da) begin
      if (hit) begin
        xl.paddr = {dseg, va[28:0]};
        xl.mat   = dmat;
      end else begin
        xl.mat = tlb_mat;
        if (tlb_ps == PS_2M)
          xl.paddr = {tlb_ppn[19:9], va[20:0]};
        else
          xl.paddr = {tlb_ppn, va[11:0]};
      end
    end
    if (ale)
      xl.exc = EXC_ALE;
    else if (adem)
      xl.exc = EXC_ADEM;
    else if (tlb_path) begin
      if (!tlb_found)
        xl.exc = EXC_TLBR;
      else if (!tlb_v)
        xl.exc = op.store ? EXC_PIS : EXC_PIL;
      else if (csr_plv > tlb_plv)
        xl.exc = EXC_PPI;
      else if (op.store && !tlb_d)
        xl.exc = EXC_PME;
    end
  end

  // store lane strobes and data replication
  always_comb begin
    wstrb = 4'b1111;
    wdata = op.wdata;
    unique case (op.size)
      2'd0: begin
        wstrb = 4'b0001 << va[1:0];
        wdata = {4{op.wdata[7:0]}};
      end
      2'd1: begin
        wstrb = va[1] ? 4'b1100 : 4'b0011;
        wdata = {2{op.wdata[15:0]}};
      end
      default: ;
    endcase
    if (!op.store)
      wstrb = 4'b0000;
  end

  // next-state logic; flush returns to idle from anywhere
  always_comb begin
    st_n = st;
    unique case (st)
      S_IDLE:   if (accept) st_n = S_LOOKUP;
      S_LOOKUP: st_n = (xl.exc != EXC_NONE) ?
                       S_DONE : S_ISSUE;
      S_ISSUE:  if (fire) st_n = S_DONE;
      S_DONE:   if (out_ready)
                  st_n = accept ? S_LOOKUP : S_IDLE;
      default:  st_n = S_IDLE;
    endcase
    if (flush)
      st_n = S_IDLE;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) st <= S_IDLE;
    else         st <= st_n;
  end

  // capture the accepted op
  always_ff @(posedge clk) begin
    if (!resetn)
      op <= '0;
    else if (accept)
      op <= '{vaddr: in_vaddr, wdata: in_wdata,
              store: in_store, load: in_load,
              size:  in_size};
  end

  // capture translation result at the end of lookup
  always_ff @(posedge clk) begin
    if (!resetn)
      res <= '0;
    else if (st == S_LOOKUP && !flush)
      res <= xl;
  end

  // outstanding request counter, survives flush
  always_ff @(posedge clk) begin
    if (!resetn)
      cnt <= '0;
    else begin
      unique case ({fire, data_ok})
        2'b10: if (cnt < MAXC) cnt <= cnt + 3'd1;
        2'b01: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_xlate_issue.sv
// Scoreboard bench for lsu_xlate_issue: directed ops push expected
// issue/result records, monitors pop and compare on handshakes.
module tb_lsu_xlate_issue;

  typedef struct packed {
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } iss_t;

  typedef struct packed {
    logic [2:0]  exc;
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        load;
  } rs_t;

  logic        clk, resetn, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_vaddr, in_wdata;
  logic        in_store, in_load;
  logic [1:0]  in_size;
  logic [1:0]  csr_plv, csr_datm;
  logic        csr_da;
  logic [9:0]  csr_asid;
  logic [19:0] csr_dmw;
  logic [18:0] tlb_vppn;
  logic        tlb_va_bit12;
  logic [9:0]  tlb_asid;
  logic        tlb_found, tlb_v, tlb_d;
  logic [19:0] tlb_ppn;
  logic [5:0]  tlb_ps;
  logic [1:0]  tlb_plv, tlb_mat;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic        out_valid, out_ready;
  logic [2:0]  out_exc;
  logic [31:0] out_paddr;
  logic [1:0]  out_mat;
  logic        out_load;

  int checks = 0;
  int errors = 0;
  iss_t iss_q[$];
  rs_t  res_q[$];
  logic [18:0] lk_vppn;
  logic        lk_b12;

  lsu_xlate_issue #(.NUM_DMW(2), .MAX_OUTST(2)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vaddr(in_vaddr), .in_wdata(in_wdata),
    .in_store(in_store), .in_load(in_load),
    .in_size(in_size), .csr_plv(csr_plv),
    .csr_da(csr_da), .csr_datm(csr_datm),
    .csr_asid(csr_asid), .csr_dmw(csr_dmw),
    .tlb_vppn(tlb_vppn), .tlb_va_bit12(tlb_va_bit12),
    .tlb_asid(tlb_asid), .tlb_found(tlb_found),
    .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_ppn(tlb_ppn),
    .tlb_ps(tlb_ps), .tlb_plv(tlb_plv),
    .tlb_mat(tlb_mat), .req(req), .wr(wr),
    .size(size), .wstrb(wstrb), .addr(addr),
    .wdata(wdata), .addr_ok(addr_ok),
    .data_ok(data_ok), .out_valid(out_valid),
    .out_ready(out_ready), .out_exc(out_exc),
    .out_paddr(out_paddr), .out_mat(out_mat),
    .out_load(out_load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string n,
                       input logic [127:0] a,
                       input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic timeout(input string n);
    checks++;
    errors++;
    $display("FAIL %s timed out", n);
  endtask

  // issue monitor
  always @(negedge clk) begin
    if (resetn === 1'b1 && req && addr_ok) begin
      if (iss_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_unexpected got %h want none",
                 addr);
      end else begin
        iss_t e;
        e = iss_q.pop_front();
        check("issue", {wr, wstrb, addr, wdata}, e);
      end
    end
  end

  // result monitor
  always @(negedge clk) begin
    if (resetn === 1'b1 && out_valid && out_ready) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected got %h want none",
                 out_paddr);
      end else begin
        rs_t e;
        e = res_q.pop_front();
        check("result",
              {out_exc, out_paddr, out_mat, out_load}, e);
      end
    end
  end

  task automatic send(input logic [31:0] va,
                      input logic [31:0] wd,
                      input logic st,
                      input logic [1:0] sz);
    int n = 0;
    in_vaddr = va;
    in_wdata = wd;
    in_store = st;
    in_load  = ~st;
    in_size  = sz;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) timeout("accept");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_lat(input int rk, input int vk,
                            input string n);
    int fr = -1;
    int fv = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        lk_vppn = tlb_vppn;
        lk_b12  = tlb_va_bit12;
      end
      if (req && fr < 0) fr = k;
      if (out_valid) begin
        fv = k;
        break;
      end
    end
    if (fv < 0) timeout({n, "_valid"});
    else begin
      check({n, "_req_lat"}, fr, rk);
      check({n, "_val_lat"}, fv, vk);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic dok();
    data_ok = 1'b1;
    @(posedge clk);
    #1 data_ok = 1'b0;
  endtask

  task automatic hold_low(input int cyc, input string n);
    for (int k = 0; k < cyc; k++) begin
      @(negedge clk);
      check(n, req, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic norm_ld(input logic [31:0] va);
    iss_q.push_back('{1'b0, 4'h0,
                      {20'h12345, va[11:0]}, 32'h0});
    res_q.push_back('{3'd0, {20'h12345, va[11:0]},
                      2'd2, 1'b1});
    send(va, 32'h0, 1'b0, 2'd2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    resetn = 0; flush = 0; in_valid = 0;
    in_vaddr = 0; in_wdata = 0; in_store = 0;
    in_load = 0; in_size = 0;
    csr_plv = 0; csr_da = 0; csr_datm = 0;
    csr_asid = 10'h155; csr_dmw = 0;
    tlb_found = 0; tlb_v = 0; tlb_d = 0;
    tlb_ppn = 0; tlb_ps = 0; tlb_plv = 0; tlb_mat = 0;
    addr_ok = 1; data_ok = 0; out_ready = 1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ctl", {req, wr, out_valid}, 3'b000);
    check("rst_bus", {size, wstrb, addr, wdata}, 70'h0);
    check("rst_out",
          {out_exc, out_paddr, out_mat, out_load}, 38'h0);
    check("tlb_asid", tlb_asid, 10'h155);
    @(posedge clk);
    #1 resetn = 1;

    csr_da = 1; csr_datm = 2'd1;
    iss_q.push_back('{1'b0, 4'h0, 32'h1C000104, 32'h0});
    res_q.push_back('{3'd0, 32'h1C000104, 2'd1, 1'b1});
    send(32'h1C000104, 32'h0, 1'b0, 2'd2);
    expect_lat(1, 2, "da_ld");
    dok();

    csr_da = 0; csr_plv = 0;
    csr_dmw = {10'h0, 10'h2A1};
    iss_q.push_back('{1'b1, 4'b1000, 32'h13, 32'hABABABAB});
    res_q.push_back('{3'd0, 32'h13, 2'd1, 1'b0});
    send(32'hA0000013, 32'hAB, 1'b1, 2'd0);
    expect_lat(1, 2, "dmw_stb");
    dok();

    tlb_found = 1; tlb_v = 1; tlb_d = 1;
    tlb_ps = 6'd21; tlb_ppn = 20'h12345;
    tlb_plv = 0; tlb_mat = 2'd2;
    iss_q.push_back('{1'b1, 4'b1100, 32'h12300002,
                      32'h56785678});
    res_q.push_back('{3'd0, 32'h12300002, 2'd2, 1'b0});
    send(32'h00100002, 32'h5678, 1'b1, 2'd1);
    expect_lat(1, 2, "tlb_sth");
    check("tlb_vppn", {lk_vppn, lk_b12}, {19'h80, 1'b0});
    dok();

    tlb_d = 0;
    res_q.push_back('{3'd7, 32'h12300002, 2'd2, 1'b0});
    send(32'h00100002, 32'h5678, 1'b1, 2'd1);
    expect_lat(-1, 1, "pme");
    tlb_d = 1;

    csr_da = 1;
    res_q.push_back('{3'd1, 32'h1002, 2'd1, 1'b1});
    send(32'h1002, 32'h0, 1'b0, 2'd2);
    expect_lat(-1, 1, "ale");
    csr_da = 0;

    tlb_ps = 6'd12; csr_plv = 3;
    res_q.push_back('{3'd2, 32'h12345000, 2'd2, 1'b1});
    send(32'h90000000, 32'h0, 1'b0, 2'd2);
    expect_lat(-1, 1, "adem");

    res_q.push_back('{3'd6, 32'h12345000, 2'd2, 1'b1});
    send(32'h00002000, 32'h0, 1'b0, 2'd2);
    expect_lat(-1, 1, "ppi");
    csr_plv = 0;

    tlb_found = 0;
    res_q.push_back('{3'd3, 32'h12345004, 2'd2, 1'b1});
    send(32'h00003004, 32'h0, 1'b0, 2'd2);
    expect_lat(-1, 1, "tlbr");
    tlb_found = 1;

    tlb_v = 0;
    res_q.push_back('{3'd4, 32'h12345008, 2'd2, 1'b1});
    send(32'h00004008, 32'h0, 1'b0, 2'd2);
    expect_lat(-1, 1, "pil");
    res_q.push_back('{3'd5, 32'h1234500C, 2'd2, 1'b0});
    send(32'h0000400C, 32'h11, 1'b1, 2'd0);
    expect_lat(-1, 1, "pis");
    tlb_v = 1;

    norm_ld(32'h100);
    expect_lat(1, 2, "outst_a");
    norm_ld(32'h104);
    expect_lat(1, 2, "outst_b");
    norm_ld(32'h108);
    hold_low(4, "outst_hold");
    dok();
    expect_lat(0, 1, "outst_rel");
    dok();
    dok();

    norm_ld(32'h110);
    expect_lat(1, 2, "fl_d1");
    send(32'h114, 32'h0, 1'b0, 2'd2);
    @(negedge clk);
    @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("flush_req", req, 1'b0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("flush_idle", {in_ready, out_valid}, 2'b10);
    @(posedge clk);
    #1;
    norm_ld(32'h118);
    expect_lat(1, 2, "fl_e");
    norm_ld(32'h11C);
    hold_low(3, "flush_cnt");
    dok();
    expect_lat(0, 1, "fl_f");
    dok();
    dok();

    out_ready = 0;
    norm_ld(32'h120);
    expect_lat(1, 2, "stall");
    @(negedge clk);
    check("stall_hold", out_valid, 1'b1);
    check("stall_pa", out_paddr, 32'h12345120);
    @(posedge clk);
    #1 out_ready = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    dok();

    addr_ok = 0;
    send(32'h124, 32'h0, 1'b0, 2'd2);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_pre_req", req, 1'b1);
    @(posedge clk);
    #1 resetn = 0;
    @(posedge clk);
    #1 resetn = 1;
    @(negedge clk);
    check("rst2_ctl", {req, wr, out_valid, in_ready},
          4'b0001);
    check("rst2_bus", {size, wstrb, addr, wdata}, 70'h0);
    check("rst2_out",
          {out_exc, out_paddr, out_mat, out_load}, 38'h0);
    addr_ok = 1;

    @(posedge clk);
    #1;
    check("sb_empty", iss_q.size() + res_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
